// File: rtl/booth_sched.sv
// booth_sched: round-robin scheduler/sequencer sharing one Booth multiplier
// datapath among N_REQ requesters.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   req                 per-requester request level, held until own done
//   op_m, op_q          packed per-requester multiplicand / multiplier
//   gnt                 one-hot grant, held from grant through DONE
//   busy                high whenever the sequencer is not idle
//   dp_m, dp_q          granted operands steered to the datapath (0 if no grant)
//   carga/suma/resta/desplaza  datapath control strobes
//   q0, qm1             datapath Q[0] and Qm1 feedback
//   dp_product          datapath {A,Q}
//   result              last completed product
//   done                one-cycle pulse on the bit of the finished requester
module booth_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   op_m,
    input  logic [N_REQ*WIDTH-1:0]   op_q,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic [WIDTH-1:0]         dp_m,
    output logic [WIDTH-1:0]         dp_q,
    output logic                     carga,
    output logic                     suma,
    output logic                     resta,
    output logic                     desplaza,
    input  logic                     q0,
    input  logic                     qm1,
    input  logic [2*WIDTH-1:0]       dp_product,
    output logic [2*WIDTH-1:0]       result,
    output logic [N_REQ-1:0]         done
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int unsigned IDX_W = PTR_W + 1;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] EVAL  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 arb_found;
    logic [PTR_W-1:0]     arb_idx;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     ptr_inc;

    // Round-robin search: first set request starting at ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = IDX_W'(ptr_q) + IDX_W'(k);
            if (cand >= IDX_W'(N_REQ)) begin
                cand = cand - IDX_W'(N_REQ);
            end
            if (!arb_found && req[cand[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Pointer value after serving the granted requester.
    always_comb begin
        ptr_inc = IDX_W'(gidx_q) + IDX_W'(1);
        if (ptr_inc >= IDX_W'(N_REQ)) begin
            ptr_inc = '0;
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            gidx_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            result_q <= result_d;
        end
    end

    // Next-state logic and datapath control decode.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        result_d = result_q;
        carga    = 1'b0;
        suma     = 1'b0;
        resta    = 1'b0;
        desplaza = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_d   = N_REQ'(1) << arb_idx;
                    gidx_d  = arb_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                carga   = 1'b1;
                cnt_d   = '0;
                state_d = EVAL;
            end
            EVAL: begin
                // Booth recoding of the live {Q[0], Qm1} pair.
                case ({q0, qm1})
                    2'b10:   resta = 1'b1;
                    2'b01:   suma  = 1'b1;
                    default: ;
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                desplaza = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = EVAL;
                end
            end
            DONE: begin
                result_d = dp_product;
                ptr_d    = ptr_inc[PTR_W-1:0];
                gnt_d    = '0;
                state_d  = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Operand steering: AND-OR mux over the one-hot grant, 0 when idle.
    always_comb begin
        dp_m = '0;
        dp_q = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            dp_m = dp_m | (op_m[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}});
            dp_q = dp_q | (op_q[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}});
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE) ? gnt_q : '0;
    // Final product is visible in the same cycle as its done pulse.
    assign result = (state_q == DONE) ? dp_product : result_q;

endmodule

// File: tb/tb_booth_sched.sv
module tb_booth_sched;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic               clk;
    logic               reset_n;
    logic [N-1:0]       req;
    logic [N*W-1:0]     op_m;
    logic [N*W-1:0]     op_q;
    logic [N-1:0]       gnt;
    logic               busy;
    logic [W-1:0]       dp_m;
    logic [W-1:0]       dp_q;
    logic               carga, suma, resta, desplaza;
    logic               q0, qm1;
    logic [2*W-1:0]     dp_product;
    logic [2*W-1:0]     result;
    logic [N-1:0]       done;

    booth_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .op_m       (op_m),
        .op_q       (op_q),
        .gnt        (gnt),
        .busy       (busy),
        .dp_m       (dp_m),
        .dp_q       (dp_q),
        .carga      (carga),
        .suma       (suma),
        .resta      (resta),
        .desplaza   (desplaza),
        .q0         (q0),
        .qm1        (qm1),
        .dp_product (dp_product),
        .result     (result),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Booth datapath; A carries one guard bit so -M never overflows.
    logic [W:0]   m_a;
    logic [W-1:0] m_q, m_m;
    logic         m_qm1;
    logic         force_en, fq0, fqm1;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_a <= '0; m_q <= '0; m_m <= '0; m_qm1 <= 1'b0;
        end else if (carga) begin
            m_a <= '0; m_q <= dp_q; m_m <= dp_m; m_qm1 <= 1'b0;
        end else if (suma) begin
            m_a <= m_a + {m_m[W-1], m_m};
        end else if (resta) begin
            m_a <= m_a - {m_m[W-1], m_m};
        end else if (desplaza) begin
            {m_a, m_q, m_qm1} <= {m_a[W], m_a, m_q};
        end
    end

    assign dp_product = {m_a[W-1:0], m_q};
    assign q0  = force_en ? fq0  : m_q[0];
    assign qm1 = force_en ? fqm1 : m_qm1;

    typedef struct {
        int           idx;
        logic [2*W-1:0] res;
        bit           chk;
        int           n_suma;   // -1: not checked
        int           n_resta;  // -1: not checked
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_op(input int idx, input logic [2*W-1:0] res, input bit chk,
                             input int ns, input int nr);
        exp_t e;
        e.idx = idx; e.res = res; e.chk = chk; e.n_suma = ns; e.n_resta = nr;
        sb.push_back(e);
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
        op_m[i*W +: W] = m;
        op_q[i*W +: W] = q;
    endtask

    // Wait (bounded) for the negedge at which done[idx] is high.
    task automatic wait_done(input int idx);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done[idx]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: requester %0d got no done within 200 cycles", idx);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse and checks per-op traces.
    initial begin : monitor
        logic [N-1:0] prev_gnt;
        int cyc, t_gnt, n_carga, n_suma, n_resta, n_desp;
        exp_t e;
        prev_gnt = '0; cyc = 0; t_gnt = 0;
        n_carga = 0; n_suma = 0; n_resta = 0; n_desp = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                check("ctrl_exclusive", 64'($countones({carga, suma, resta, desplaza}) > 1), 64'(0));
                if (gnt != '0 && prev_gnt == '0) begin
                    t_gnt = cyc;
                    n_carga = 0; n_suma = 0; n_resta = 0; n_desp = 0;
                    if (sb.size() == 0) check("unexpected_grant", gnt, 0);
                    else                check("grant_order", gnt, N'(1) << sb[0].idx);
                end
                n_carga += int'(carga);
                n_suma  += int'(suma);
                n_resta += int'(resta);
                n_desp  += int'(desplaza);
                if (done != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_bit", done, N'(1) << e.idx);
                        check("gnt_at_done", gnt, N'(1) << e.idx);
                        if (e.chk) check("result", result, e.res);
                        // LOAD cycle to DONE cycle is 2*W+1 cycles.
                        check("latency", 64'(cyc - t_gnt), 64'(2*W + 1));
                        check("carga_count", 64'(n_carga), 64'(1));
                        check("desplaza_count", 64'(n_desp), 64'(W));
                        if (e.n_suma  >= 0) check("suma_count",  64'(n_suma),  64'(e.n_suma));
                        if (e.n_resta >= 0) check("resta_count", 64'(n_resta), 64'(e.n_resta));
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},      gnt, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_result"},   result, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_ctrl"},     {carga, suma, resta, desplaza}, 0);
        check({tag, "_dp_ops"},   {dp_m, dp_q}, 0);
    endtask

    initial begin : stimulus
        int nd;
        reset_n = 1'b0; req = '0; force_en = 1'b0; fq0 = 1'b0; fqm1 = 1'b0;
        op_m = '0; op_q = '0;
        set_slot(0, 8'hFD, 8'h05);   // -3 * 5    = -15   = 16'hFFF1
        set_slot(1, 8'h0C, 8'hF9);   // 12 * -7   = -84   = 16'hFFAC
        set_slot(2, 8'h7F, 8'h7F);   // 127 * 127 = 16129 = 16'h3F01
        set_slot(3, 8'hFF, 8'hFF);   // -1 * -1   = 1
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // All requesters held: order 0,1,2,3,0.
        expect_op(0, 16'hFFF1, 1, -1, -1);
        expect_op(1, 16'hFFAC, 1, -1, -1);
        expect_op(2, 16'h3F01, 1, -1, -1);
        expect_op(3, 16'h0001, 1, -1, -1);
        expect_op(0, 16'hFFF1, 1, -1, -1);
        req = 4'b1111;
        wait_done(0); wait_done(1); wait_done(2); wait_done(3); wait_done(0);
        req = '0;
        @(negedge clk);

        // Single requester, small and signed operands.
        set_slot(0, 8'd7, 8'd3);
        expect_op(0, 16'd21, 1, -1, -1);
        req = 4'b0001; wait_done(0); req = '0;
        set_slot(0, 8'hFB, 8'd3);
        expect_op(0, 16'hFFF1, 1, -1, -1);
        req = 4'b0001; wait_done(0); req = '0;
        set_slot(0, 8'h80, 8'h80);
        expect_op(0, 16'h4000, 1, -1, -1);
        req = 4'b0001; wait_done(0); req = '0;
        set_slot(0, 8'hFD, 8'h05);

        // Serve 2, then 1001 must go to 3 before 0.
        expect_op(2, 16'h3F01, 1, -1, -1);
        req = 4'b0100; wait_done(2); req = '0;
        expect_op(3, 16'h0001, 1, -1, -1);
        expect_op(0, 16'hFFF1, 1, -1, -1);
        req = 4'b1001;
        wait_done(3); req = 4'b0001;
        wait_done(0); req = '0;

        // Request dropped mid-operation still completes.
        expect_op(1, 16'hFFAC, 1, -1, -1);
        req = 4'b0010;
        repeat (5) @(negedge clk);
        req = '0;
        wait_done(1);

        // Forced Booth pairs: 10 -> resta only, 01 -> suma only, 11 -> neither.
        force_en = 1'b1;
        fq0 = 1'b1; fqm1 = 1'b0;
        expect_op(0, '0, 0, 0, W);
        req = 4'b0001; wait_done(0); req = '0;
        fq0 = 1'b0; fqm1 = 1'b1;
        expect_op(0, '0, 0, W, 0);
        req = 4'b0001; wait_done(0); req = '0;
        fq0 = 1'b1; fqm1 = 1'b1;
        expect_op(0, '0, 0, 0, 0);
        req = 4'b0001; wait_done(0); req = '0;
        force_en = 1'b0;
        @(negedge clk);

        // Reset during the third SHIFT aborts the operation.
        expect_op(2, 16'h3F01, 1, -1, -1);
        req = 4'b0100;
        nd = 0;
        for (int i = 0; i < 100 && nd < 3; i++) begin
            @(negedge clk);
            if (desplaza) nd++;
        end
        if (nd < 3) begin
            checks++; errors++;
            $display("FAIL shift_timeout: saw %0d shifts, needed 3", nd);
        end
        reset_n = 1'b0;
        req = '0;
        sb.delete();
        @(negedge clk);
        check_all_zero("midreset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_no_done", done, 0);

        // Pointer restarts at 0.
        expect_op(0, 16'hFFF1, 1, -1, -1);
        req = 4'b1111;
        wait_done(0);
        req = '0;
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
